if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
- Instruction prefetch stage between the CPU fetch port and the instruction ROM in the minimal SoC.
- Generates sequential ROM addresses and captures returned words into a small FIFO.
- Hands {pc, inst} to the CPU fetch stage with a valid/ready handshake.
- Supports redirect (branch/jump/exception flush) that discards queued and in-flight words.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 32'h00000000, first fetch address after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- rom_ce_o  output  1  ROM read enable; request issued this cycle when 1
- rom_addr_o  output  32  ROM byte address, meaningful when rom_ce_o=1
- rom_data_i  input  32  ROM read data; valid exactly 1 cycle after the request (registered ROM)
- flush_i  input  1  redirect request
- flush_pc_i  input  32  redirect target, sampled when flush_i=1
- inst_valid_o  output  1  queue head valid
- inst_o  output  32  head instruction word
- inst_pc_o  output  32  head instruction address
- inst_ready_i  input  1  consumer accepts head when inst_valid_o&inst_ready_i

Behaviour:
- Reset (async, rst=1): rom_ce_o=0, rom_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0; queue empty, no request in flight, fetch pointer fetch_pc=RESET_PC.
- Outputs rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o are registered or driven from registered state only; no combinational path from any input to any output.
- States: RUN, REDIRECT.
  - RUN: issue request at fetch_pc when count + inflight + (issue this cycle) <= DEPTH; on issue fetch_pc += PC_STEP (wraps modulo 2^32).
  - REDIRECT: entered the cycle after flush_i sampled; rom_ce_o=0 for that cycle; fetch_pc loaded with flush_pc_i; returns to RUN next cycle.
- Request pipeline: request issued at cycle n (rom_ce_o=1 at n) writes {addr, rom_data_i} into the tail at the end of cycle n+1; max 1 in flight per cycle, up to DEPTH in flight total.
- First request after reset release: rom_ce_o=1 with rom_addr_o=RESET_PC in the first cycle after rst deasserts. First inst_valid_o=1 two cycles after that.
- Handshake: head pops when inst_valid_o&inst_ready_i. inst_o/inst_pc_o hold stable while valid&!ready. Push and pop in the same cycle are allowed at any occupancy, including full.
- Full: no issue when count + inflight = DEPTH; issue resumes the cycle after a pop frees a slot.
- Empty: inst_valid_o=0; inst_o/inst_pc_o hold their last values.
- Flush (flush_i=1 at cycle f):
  - At end of f: queue cleared; any response arriving at f+1 for a pre-flush request is discarded (kill flag).
  - A pop that handshakes in cycle f still completes.
  - inst_valid_o=0 from f+1.
  - Request to flush_pc_i issued at f+2; its instruction is valid at f+4 earliest.
- Flush while in REDIRECT: the newer flush_pc_i wins; REDIRECT is extended by one cycle.
- Flush with empty queue and nothing in flight: same timing.
- flush_i has priority over issue in the same cycle; no request is issued in cycle f.
- Reset mid-operation: all state returns to reset values immediately; late ROM data after reset is ignored.

Optional Feature:
- Macro IF_PREFETCH_STATS_EN. When defined, adds two output ports:
  - stat_flush_o[31:0]: counts flushes.
  - stat_starve_o[31:0]: counts cycles with inst_valid_o=0 and inst_ready_i=1.
  - Both counters are reset to 0, saturate at 32'hFFFFFFFF, and update one cycle after the event.
- When the macro is undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, inst_ready_i=1, ROM[i]=i: rom_addr_o sequence 0,4,8,...; inst_pc_o/inst_o pairs (0,0),(4,1),(8,2); one instruction per cycle in steady state.
- inst_ready_i=0 for 10 cycles: exactly DEPTH=4 requests issued, then rom_ce_o=0; inst_o holds word 0. Ready=1: words 0..N delivered with no gaps or duplicates.
- flush_i=1, flush_pc_i=32'h100 with 3 words queued and 1 in flight: no stale word ever presented; first valid is inst_pc_o=32'h100 at f+4.
- Back-to-back flushes to 32'h200 then 32'h300: only 32'h300 stream appears.
- fetch_pc=32'hFFFFFFF8: addresses FFFFFFF8, FFFFFFFC, 00000000.
- rst asserted mid-stream with queue full: all outputs 0 immediately; restart from RESET_PC.
- With IF_PREFETCH_STATS_EN: after 2 flushes and the starvation in the first scenario, stat_flush_o=2 and stat_starve_o equals the counted starved cycles.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between the CPU fetch port and a registered instruction ROM.
// Issues sequential ROM reads, captures each returned word with its address in a small
// FIFO and presents the head to the fetch stage through a valid/ready handshake. A
// redirect (flush_i) discards queued words and the response still in flight, then
// restarts fetching at flush_pc_i.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rom_ce_o        ROM read enable (one request per cycle when high)
//   rom_addr_o      ROM byte address of the request
//   rom_data_i      ROM read data, valid one cycle after the request
//   flush_i         redirect request; flush_pc_i is the redirect target
//   inst_valid_o    head of queue valid
//   inst_o          head instruction word
//   inst_pc_o       head instruction address
//   inst_ready_i    consumer accepts the head when inst_valid_o & inst_ready_i
//   stat_flush_o    (IF_PREFETCH_STATS_EN only) saturating count of flushes
//   stat_starve_o   (IF_PREFETCH_STATS_EN only) saturating count of cycles with
//                   inst_valid_o=0 and inst_ready_i=1
//
// Optional feature: define IF_PREFETCH_STATS_EN to add the two statistics counters.
// All outputs come straight from flops; inputs only reach next-state logic.

module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
`ifdef IF_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_flush_o,
  output logic [31:0] stat_starve_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [0:0] {StRun, StRedirect} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            rom_ce_q, rom_ce_d;
  logic [31:0]     rom_addr_q, rom_addr_d;
  logic            resp_q;      // a ROM response is on rom_data_i this cycle
  logic [31:0]     resp_pc_q;   // address of that response
  logic [CW-1:0]   used_q, used_d;   // queued entries plus requests not yet written
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            valid_q, valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic [31:0]     mem_inst_q [DEPTH];
  logic [31:0]     mem_pc_q   [DEPTH];

  logic            pop;
  logic            push;
  logic [CW-1:0]   cnt_after_pop;
  logic [CW-1:0]   used_after_pop;

  assign pop = valid_q & inst_ready_i;
  // REDIRECT doubles as the kill flag: the response arriving then belongs to a request
  // issued before the flush. A response during the flush cycle itself is dropped too.
  assign push = resp_q & (state_q == StRun) & ~flush_i;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    rom_ce_d       = 1'b0;
    rom_addr_d     = rom_addr_q;
    used_d         = used_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    cnt_after_pop  = count_q - CW'(pop);
    used_after_pop = used_q - CW'(pop);

    if (flush_i) begin
      // Flush beats issue: nothing is launched for next cycle and the queue empties.
      state_d    = StRedirect;
      fetch_pc_d = flush_pc_i;
      used_d     = '0;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      state_d = StRun;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = cnt_after_pop + 1'b1;
      end else begin
        count_d  = cnt_after_pop;
      end
      // Reserve a slot at decision time so a full queue never receives a response.
      if (used_after_pop < CW'(DEPTH)) begin
        rom_ce_d   = 1'b1;
        rom_addr_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_STEP;
        used_d     = used_after_pop + 1'b1;
      end else begin
        used_d     = used_after_pop;
      end
    end

    valid_d = (count_d != '0);
    // Head registers only change when something is queued, so they hold when empty.
    if (valid_d) begin
      if (push && (cnt_after_pop == '0)) begin
        inst_d    = rom_data_i;
        inst_pc_d = resp_pc_q;
      end else begin
        inst_d    = mem_inst_q[rd_ptr_d];
        inst_pc_d = mem_pc_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      rom_ce_q   <= 1'b0;
      rom_addr_q <= '0;
      resp_q     <= 1'b0;
      resp_pc_q  <= '0;
      used_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rom_ce_q   <= rom_ce_d;
      rom_addr_q <= rom_addr_d;
      resp_q     <= rom_ce_q;
      resp_pc_q  <= rom_addr_q;
      used_q     <= used_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= rom_data_i;
      mem_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assign rom_ce_o     = rom_ce_q;
  assign rom_addr_o   = rom_addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

`ifdef IF_PREFETCH_STATS_EN
  logic [31:0] stat_flush_q, stat_flush_d;
  logic [31:0] stat_starve_q, stat_starve_d;

  always_comb begin
    stat_flush_d  = stat_flush_q;
    stat_starve_d = stat_starve_q;
    if (flush_i && (stat_flush_q != '1)) begin
      stat_flush_d = stat_flush_q + 32'd1;
    end
    if (!valid_q && inst_ready_i && (stat_starve_q != '1)) begin
      stat_starve_d = stat_starve_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flush_q  <= '0;
      stat_starve_q <= '0;
    end else begin
      stat_flush_q  <= stat_flush_d;
      stat_starve_q <= stat_starve_d;
    end
  end

  assign stat_flush_o  = stat_flush_q;
  assign stat_starve_o = stat_starve_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a registered ROM model returns addr>>2 for each
// address; a scoreboard of expected head PCs is loaded whenever the fetch stream is
// (re)started and every accepted word is checked against it.

module tb_if_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
`ifdef IF_PREFETCH_STATS_EN
  logic [31:0] stat_flush_o;
  logic [31:0] stat_starve_o;
`endif

  int n_vec   = 0;
  int n_miss  = 0;
  int n_deliv = 0;
  int n_flush = 0;
  int n_starve = 0;
  int n_ce    = 0;
  logic [31:0] sb_pc [$];

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
`ifdef IF_PREFETCH_STATS_EN
    ,
    .stat_flush_o  (stat_flush_o),
    .stat_starve_o (stat_starve_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Registered ROM: data for the address presented in cycle n appears in cycle n+1.
  initial rom_data_i = 32'h0;
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= rom_word(rom_addr_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_reset(input logic [31:0] base);
    sb_pc.delete();
    for (int i = 0; i < 64; i++) sb_pc.push_back(base + 32'(4 * i));
  endtask

  // One clock cycle with the currently driven inputs; outputs sampled mid-cycle.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    if (!rst) begin
      if (flush_i) n_flush++;
      if (!inst_valid_o && inst_ready_i) n_starve++;
    end
    if (inst_valid_o && inst_ready_i) begin
      n_deliv++;
      e = (sb_pc.size() != 0) ? sb_pc.pop_front() : 32'hxxxx_xxxx;
      chk("head_pc", inst_pc_o, e);
      chk("head_inst", inst_o, rom_word(e));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    flush_pc_i = 32'h0;
    inst_ready_i = 1'b1;

    // Reset state
    cyc();
    chk("rst_ce", 32'(rom_ce_o), 32'd0);
    chk("rst_addr", rom_addr_o, 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", inst_pc_o, 32'd0);
    cyc();

    // Release: first request next cycle, first valid two cycles later
    sb_reset(RESET_PC);
    rst = 1'b0;
    chk("c0_ce", 32'(rom_ce_o), 32'd0);
    cyc();
    chk("c1_ce", 32'(rom_ce_o), 32'd1);
    chk("c1_addr", rom_addr_o, RESET_PC);
    cyc();
    chk("c2_addr", rom_addr_o, RESET_PC + 32'd4);
    chk("c2_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    chk("c3_valid", 32'(inst_valid_o), 32'd1);
    chk("c3_addr", rom_addr_o, RESET_PC + 32'd8);
    n_deliv = 0;
    repeat (8) cyc();
    chk("steady_rate", 32'(n_deliv), 32'd8);

    // Stall: issue stops once the queue is committed, head holds
    inst_ready_i = 1'b0;
    repeat (10) cyc();
    chk("stall_ce", 32'(rom_ce_o), 32'd0);
    chk("stall_valid", 32'(inst_valid_o), 32'd1);
    chk("stall_head_pc", inst_pc_o, sb_pc[0]);
    chk("stall_head_inst", inst_o, rom_word(sb_pc[0]));
    inst_ready_i = 1'b1;
    n_deliv = 0;
    repeat (10) cyc();
    chk("resume_rate", 32'(n_deliv), 32'd10);

    // Reset with the queue full
    inst_ready_i = 1'b0;
    repeat (8) cyc();
    chk("full_valid", 32'(inst_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ce", 32'(rom_ce_o), 32'd0);
    chk("midrst_addr", rom_addr_o, 32'd0);
    chk("midrst_valid", 32'(inst_valid_o), 32'd0);
    chk("midrst_inst", inst_o, 32'd0);
    chk("midrst_pc", inst_pc_o, 32'd0);
    n_flush = 0;
    n_starve = 0;
    cyc();
    cyc();
    sb_reset(RESET_PC);
    rst = 1'b0;
    n_ce = 0;
    for (int i = 0; i < 10; i++) begin
      n_ce += int'(rom_ce_o);
      cyc();
    end
    chk("fill_req_count", 32'(n_ce), 32'(DEPTH));
    chk("fill_ce", 32'(rom_ce_o), 32'd0);
    chk("fill_head_pc", inst_pc_o, RESET_PC);
    chk("fill_head_inst", inst_o, rom_word(RESET_PC));

    // One pop frees a slot -> 3 queued + 1 in flight, then flush to 0x100
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
    chk("refill_ce", 32'(rom_ce_o), 32'd1);
    chk("refill_valid", 32'(inst_valid_o), 32'd1);
    flush_i = 1'b1;
    flush_pc_i = 32'h100;
    cyc();
    flush_i = 1'b0;
    sb_reset(32'h100);
    inst_ready_i = 1'b1;
    chk("f1_valid", 32'(inst_valid_o), 32'd0);
    chk("f1_ce", 32'(rom_ce_o), 32'd0);
    cyc();
    chk("f2_ce", 32'(rom_ce_o), 32'd1);
    chk("f2_addr", rom_addr_o, 32'h100);
    cyc();
    chk("f3_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    chk("f4_valid", 32'(inst_valid_o), 32'd1);
    chk("f4_pc", inst_pc_o, 32'h100);
    repeat (6) cyc();

    // Back-to-back flushes: only the 0x300 stream may appear
    flush_i = 1'b1;
    flush_pc_i = 32'h200;
    cyc();
    sb_reset(32'h300);
    flush_pc_i = 32'h300;
    cyc();
    flush_i = 1'b0;
    chk("g2_ce", 32'(rom_ce_o), 32'd0);
    chk("g2_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    chk("g3_addr", rom_addr_o, 32'h300);
    chk("g3_ce", 32'(rom_ce_o), 32'd1);
    cyc();
    chk("g4_valid", 32'(inst_valid_o), 32'd0);
    cyc();
    chk("g5_valid", 32'(inst_valid_o), 32'd1);
    chk("g5_pc", inst_pc_o, 32'h300);
    repeat (6) cyc();

    // Address wrap
    flush_i = 1'b1;
    flush_pc_i = 32'hFFFF_FFF8;
    cyc();
    flush_i = 1'b0;
    sb_reset(32'hFFFF_FFF8);
    cyc();
    chk("wrap_a0", rom_addr_o, 32'hFFFF_FFF8);
    cyc();
    chk("wrap_a1", rom_addr_o, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_a2", rom_addr_o, 32'h0000_0000);
    chk("wrap_pc", inst_pc_o, 32'hFFFF_FFF8);
    n_deliv = 0;
    repeat (10) cyc();
    chk("wrap_rate", 32'(n_deliv), 32'd10);

`ifdef IF_PREFETCH_STATS_EN
    inst_ready_i = 1'b0;
    cyc();
    cyc();
    chk("stat_flush", stat_flush_o, 32'(n_flush));
    chk("stat_starve", stat_starve_o, 32'(n_starve));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
